posit_result_monitor: RTL
=========================

Name: posit_result_monitor

Overview:
- Synthesizable, parametrised result checker for pipelined posit arithmetic units such as the N32/ES6 divider.
- Golden results enter at issue time and travel through a latency-matched delay line. Each result is compared with the unit's output when the unit signals done.
- Reports per-sample error distance in posit ULPs and accumulates statistics: sample count, mismatch count, maximum error with its sample index, NaR mismatches and alignment faults.
- Sits beside the arithmetic unit in FPGA regression harnesses, replacing file-based error dumps.

Parameters:
- N, 32, posit word width (>=4)
- LAT, 12, unit latency in cycles from issue to done (>=1)
- CNT_W, 32, width of the saturating statistic counters
- TOL, 0, largest ULP distance still counted as a pass

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of statistics, sticky flags and delay line
- exp_valid  in  1  golden value issued this cycle (same cycle as the unit's start/operands)
- exp_data  in  N  golden posit result
- dut_done  in  1  unit output valid this cycle
- dut_out  in  N  unit posit result
- err_valid  out  1  comparison result valid
- err_diff  out  N  ULP distance of the last comparison
- err_flag  out  1  err_diff > TOL
- sample_cnt  out  CNT_W  comparisons performed
- mismatch_cnt  out  CNT_W  comparisons with err_flag=1
- max_diff  out  N  largest err_diff so far
- max_idx  out  CNT_W  sample_cnt value at which max_diff was captured (0-based)
- nar_mismatch  out  1  sticky: exactly one of golden/output was NaR
- align_err  out  1  sticky: head-valid and dut_done disagreed

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0, and all delay-line data and valid bits are 0.
- Delay line: LAT stages of {valid, data}.
  - The stage 0 load is {exp_valid, exp_data}.
  - head = stage LAT-1, so a golden value is at the head exactly LAT cycles after issue.
- Compare condition: head.valid && dut_done.
- ULP distance:
  - Treat both words as N-bit two's-complement integers, because posit ordering equals signed-integer ordering.
  - Subtract at N+1 bits and take the absolute value, saturated to 2^N-1.
  - Crossing zero is handled by the signed interpretation: 0x00000001 vs 0xFFFFFFFF gives 2.
- NaR (1 followed by N-1 zeros):
  - Both NaR: diff = 0.
  - Exactly one NaR: diff = all ones, and nar_mismatch is set.
- Output timing: err_valid, err_diff and err_flag are registered one cycle after the compare. Total latency from exp_valid to err_valid is LAT+1. err_valid is a 1-cycle pulse; err_diff holds its value between pulses.
- Statistics, updated in the same edge as err_valid:
  - sample_cnt += 1.
  - mismatch_cnt += err_flag.
  - Both counters saturate at 2^CNT_W-1.
  - If diff > max_diff (strictly), load max_diff = diff and max_idx = the pre-increment sample_cnt. Ties keep the earlier index.
- Alignment faults:
  - head.valid && !dut_done, or !head.valid && dut_done, sets align_err.
  - No comparison is made and the counters are unchanged.
  - A head entry that is not consumed is dropped.
- Back-to-back: one comparison per cycle is sustained, with no bubbles required.
- clr=1:
  - Next edge zeros the statistics, sticky flags, err_* outputs and all delay-line valid bits.
  - clr has priority over a simultaneous compare or exp_valid.
- Reset mid-stream: in-flight golden values are discarded, and no err_valid is produced for them after release.

Decomposition:
- posit_pkg holds:
  - function posit_nar(N) returning the NaR pattern;
  - function posit_ulp_dist(a, b) implementing the signed-distance, saturation and NaR rules;
  - the default width constants.
- One sub-module, posit_delay_line: a parametrised LAT x (N+1) shift register with async active-low reset and sync flush. It is reused for operand alignment elsewhere.

Test Plan:
- Match: issue exp 0x40000000 at cycle 0, dut_done with dut_out 0x40000000 at cycle 12 -> err_valid at cycle 13, err_diff 0, err_flag 0, sample_cnt 1, mismatch_cnt 0.
- Distance and maximum:
  - Issue exp 0x40000003, out 0x40000001 -> err_diff 2, err_flag 1, max_diff 2, max_idx 0.
  - Next sample, diff 2 -> max_idx stays 0.
- Sign crossing and NaR:
  - exp 0x00000001, out 0xFFFFFFFF -> err_diff 2.
  - exp 0x80000000, out 0x80000000 -> diff 0.
  - exp 0x80000000, out 0x40000000 -> diff 0xFFFFFFFF, nar_mismatch 1.
- Alignment: dut_done at cycle 11 with no head entry -> align_err 1, no err_valid, counters unchanged. Then clr -> align_err 0.
- Saturation (CNT_W=4): 20 consecutive back-to-back mismatches -> err_valid high 20 cycles, mismatch_cnt and sample_cnt hold 15.
- Reset mid-stream: 5 values in flight, pulse rst_n low -> outputs 0 immediately, no err_valid in the 13 cycles after release.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit helpers: NaR pattern, signed ULP distance and default widths.
// Functions work on a 64-bit container; callers pass the live width n.
package posit_pkg;

  localparam int unsigned POSIT_MAX_W     = 64;
  localparam int unsigned POSIT_N_DEF     = 32;
  localparam int unsigned POSIT_LAT_DEF   = 12;
  localparam int unsigned POSIT_CNT_W_DEF = 32;

  typedef logic [POSIT_MAX_W-1:0] posit_word_t;
  typedef logic [POSIT_MAX_W:0]   posit_ext_t;

  localparam posit_ext_t POSIT_EXT_ONE = posit_ext_t'(1);

  // NaR is a lone sign bit: 1 followed by n-1 zeros.
  function automatic posit_word_t posit_nar(input int unsigned n);
    posit_word_t r;
    r        = '0;
    r[n-1]   = 1'b1;
    return r;
  endfunction

  function automatic logic posit_is_nar(input posit_word_t a, input int unsigned n);
    return a == posit_nar(n);
  endfunction

  // Posit order equals two's-complement order, so the distance is |a-b| taken
  // on the sign-extended words, one bit wider than n so it cannot overflow.
  function automatic posit_word_t posit_ulp_dist(input posit_word_t a,
                                                 input posit_word_t b,
                                                 input int unsigned n);
    posit_ext_t              lim, ua, ub, mag;
    logic signed [POSIT_MAX_W:0] sa, sb, d;
    posit_word_t             mask, ma, mb;
    int unsigned             sh;
    logic                    a_nar, b_nar;

    lim   = (POSIT_EXT_ONE << n) - POSIT_EXT_ONE;
    mask  = lim[POSIT_MAX_W-1:0];
    ma    = a & mask;
    mb    = b & mask;
    sh    = POSIT_MAX_W + 1 - n;
    ua    = {1'b0, ma};
    ub    = {1'b0, mb};
    sa    = $signed(ua << sh) >>> sh;
    sb    = $signed(ub << sh) >>> sh;
    d     = sa - sb;
    mag   = d[POSIT_MAX_W] ? posit_ext_t'(-d) : posit_ext_t'(d);
    if (mag > lim) mag = lim;
    a_nar = posit_is_nar(ma, n);
    b_nar = posit_is_nar(mb, n);
    if (a_nar && b_nar)      return '0;
    else if (a_nar || b_nar) return mask;
    else                     return mag[POSIT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/posit_delay_line.sv
// LAT-deep {valid, data} shift register with async reset and synchronous flush.
// Used to align golden results (or operands) with a pipelined unit.
module posit_delay_line #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];

  // NOTE: the data array is reset as well as the valid bits so that no stale
  // golden value is ever observable after reset; this costs reset fan-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      if (flush) begin
        vld <= '0;
      end else begin
        vld[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
      end
      dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/posit_result_monitor.sv
// Compares a posit unit's results against latency-matched golden values and
// accumulates error statistics (ULP distance, max error, NaR and alignment faults).
module posit_result_monitor
  import posit_pkg::*;
#(
  parameter int unsigned N     = POSIT_N_DEF,
  parameter int unsigned LAT   = POSIT_LAT_DEF,
  parameter int unsigned CNT_W = POSIT_CNT_W_DEF,
  parameter int unsigned TOL   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             exp_valid,
  input  logic [N-1:0]     exp_data,
  input  logic             dut_done,
  input  logic [N-1:0]     dut_out,
  output logic             err_valid,
  output logic [N-1:0]     err_diff,
  output logic             err_flag,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [N-1:0]     max_diff,
  output logic [CNT_W-1:0] max_idx,
  output logic             nar_mismatch,
  output logic             align_err
);

  localparam logic [N-1:0]     NAR     = N'(posit_nar(N));
  localparam logic [N-1:0]     TOL_V   = N'(TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic         head_valid;
  logic [N-1:0] head_data;
  logic         cmp;
  logic         misalign;
  logic [N-1:0] diff_c;
  logic         flag_c;
  logic         nar_one;

  posit_delay_line #(
    .W     (N),
    .DEPTH (LAT)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clr),
    .in_valid  (exp_valid),
    .in_data   (exp_data),
    .out_valid (head_valid),
    .out_data  (head_data)
  );

  // NOTE: combinational logic uses blocking assignments with every output given
  // a value on every path, so no latch can be inferred.
  always_comb begin
    cmp      = head_valid && dut_done;
    misalign = head_valid ^ dut_done;
    diff_c   = N'(posit_ulp_dist(posit_word_t'(head_data), posit_word_t'(dut_out), N));
    flag_c   = diff_c > TOL_V;
    nar_one  = (head_data == NAR) ^ (dut_out == NAR);
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, e.g. max_idx captures the pre-increment sample_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid    <= 1'b0;
      err_diff     <= '0;
      err_flag     <= 1'b0;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      max_diff     <= '0;
      max_idx      <= '0;
      nar_mismatch <= 1'b0;
      align_err    <= 1'b0;
    end else if (clr) begin
      err_valid    <= 1'b0;
      err_diff     <= '0;
      err_flag     <= 1'b0;
      sample_cnt   <= '0;
      mismatch_cnt <= '0;
      max_diff     <= '0;
      max_idx      <= '0;
      nar_mismatch <= 1'b0;
      align_err    <= 1'b0;
    end else begin
      err_valid <= cmp;
      if (cmp) begin
        err_diff <= diff_c;
        err_flag <= flag_c;
        if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + 1'b1;
        if (flag_c && (mismatch_cnt != CNT_MAX)) mismatch_cnt <= mismatch_cnt + 1'b1;
        // Strictly greater: ties keep the earliest sample index.
        if (diff_c > max_diff) begin
          max_diff <= diff_c;
          max_idx  <= sample_cnt;
        end
        if (nar_one) nar_mismatch <= 1'b1;
      end
      if (misalign) align_err <= 1'b1;
    end
  end

endmodule
